// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN-order call scheduler with door dwell timing for the elevator car
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic                  o_door_open,
  output logic                  o_dir_up,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    door_q, door_d;
  logic                    dir_up_q, dir_up_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    cur_valid;
  logic [NUM_FLOORS-1:0]   cur_onehot;
  logic                    pend_here;
  logic                    any_above, any_below;
  logic [FLOOR_W-1:0]      low_above, high_below;
  logic [NUM_FLOORS-1:0]   call_eff;
  logic                    reload;
  logic                    open_door;

  // Locate the nearest pending floors above and below the car.
  always_comb begin
    cur_valid  = int'(i_current_floor) < NUM_FLOORS;
    cur_onehot = '0;
    if (cur_valid) cur_onehot[i_current_floor] = 1'b1;
    pend_here  = |(pend_q & cur_onehot);
    any_above  = 1'b0;
    low_above  = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pend_q[f] && f > int'(i_current_floor)) begin
        any_above = 1'b1;
        low_above = FLOOR_W'(f);
      end
    end
    any_below  = 1'b0;
    high_below = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pend_q[f] && f < int'(i_current_floor)) begin
        any_below  = 1'b1;
        high_below = FLOOR_W'(f);
      end
    end
    // A call for the floor being dwelt at extends the dwell instead of queueing.
    reload   = (state_q == S_DOOR_OPEN) && |(i_call & cur_onehot);
    call_eff = (state_q == S_DOOR_OPEN) ? (i_call & ~cur_onehot) : i_call;
  end

  // Next-state, target, direction, pending and dwell-counter decisions.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | call_eff;
    target_d  = target_q;
    door_d    = door_q;
    dir_up_d  = dir_up_q;
    cnt_d     = cnt_q;
    open_door = 1'b0;
    if (!cur_valid) begin
      state_d = S_IDLE;
      door_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          target_d = i_current_floor;
          if (pend_here) begin
            open_door = 1'b1;
          end else if (any_above && (dir_up_q || !any_below)) begin
            state_d  = S_MOVE_UP;
            dir_up_d = 1'b1;
            target_d = low_above;
          end else if (any_below) begin
            state_d  = S_MOVE_DOWN;
            dir_up_d = 1'b0;
            target_d = high_below;
          end
        end
        S_MOVE_UP: begin
          if (any_above) target_d = low_above;
          if (i_current_floor == target_q && pend_here) begin
            open_door = 1'b1;
          end else if (!any_above) begin
            state_d  = S_IDLE;
            target_d = i_current_floor;
          end
        end
        S_MOVE_DOWN: begin
          if (any_below) target_d = high_below;
          if (i_current_floor == target_q && pend_here) begin
            open_door = 1'b1;
          end else if (!any_below) begin
            state_d  = S_IDLE;
            target_d = i_current_floor;
          end
        end
        S_DOOR_OPEN: begin
          target_d = i_current_floor;
          if (reload) begin
            cnt_d = CNT_W'(DOOR_CYCLES);
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            door_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (open_door) begin
        state_d  = S_DOOR_OPEN;
        door_d   = 1'b1;
        cnt_d    = CNT_W'(DOOR_CYCLES);
        target_d = i_current_floor;
        pend_d   = pend_d & ~cur_onehot;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      target_q <= '0;
      door_q   <= 1'b0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      door_q   <= door_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_target_floor = target_q;
  assign o_door_open    = door_q;
  assign o_dir_up       = dir_up_q;
  assign o_pending      = pend_q;
  assign o_busy         = (state_q != S_IDLE) || (pend_q != '0);

endmodule
